// File: rtl/dmem_sync_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_sync_if : request/response bus between the load/store stage and dmem_sync
// Revision: 1.0
// ----------------------------------------------------------------------------
interface dmem_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    ready;
  logic                    done;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, done, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, done, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_sync : synchronous single-port data memory, byte enables, fixed latency
// Revision: 1.0
// ----------------------------------------------------------------------------
module dmem_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  dmem_sync_if.slave  bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      be_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_commit;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BYTES-1:0]      w_be;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDXW-1:0]       w_idx;
  logic                  w_misaligned;
  logic                  w_oor;
  logic                  w_fault;

  assign w_accept = (state_q == S_IDLE) && bus.req;

  // With LATENCY = 1 the commit edge is the acceptance edge, so the live bus
  // must feed the array directly; otherwise the latched copy is used.
  assign w_we    = (state_q == S_IDLE) ? bus.we    : we_q;
  assign w_addr  = (state_q == S_IDLE) ? bus.addr  : addr_q;
  assign w_wdata = (state_q == S_IDLE) ? bus.wdata : wdata_q;
  assign w_be    = (state_q == S_IDLE) ? bus.be    : be_q;

  assign w_word = w_addr >> OFFS;
  assign w_idx  = w_word[IDXW-1:0];

  if (OFFS > 0) begin : g_align
    assign w_misaligned = |w_addr[OFFS-1:0];
  end else begin : g_noalign
    assign w_misaligned = 1'b0;
  end

  if (DEPTH > 1) begin : g_range
    assign w_oor = |(w_word >> IDXW);
  end else begin : g_range_one
    assign w_oor = (w_word != '0);
  end

  assign w_fault = w_misaligned | w_oor;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          cnt_d = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d      = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d      = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset wins over a commit landing on the same edge.
  assign w_commit = w_enter_resp && w_we && !w_fault && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        be_q    <= bus.be;
      end
      if (w_enter_resp) begin
        err_q   <= w_fault;
        rdata_q <= w_fault ? '0 : mem_q[w_idx];
      end else if (state_q == S_RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (w_be[i]) begin
          mem_q[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = (state_q == S_RESP);
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_sync : directed bench over three dmem_sync instances (LATENCY 1/3/4)
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_dmem_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_p;
  logic [2:0]       req_p;
  logic [2:0]       we_p;
  logic [2:0][31:0] addr_p;
  logic [2:0][31:0] wdata_p;
  logic [2:0][3:0]  be_p;
  wire  [2:0]       ready_p;
  wire  [2:0]       done_p;
  wire  [2:0]       err_p;
  wire  [2:0][31:0] rdata_p;

  int total = 0;
  int bad   = 0;

  logic [31:0] b2b_vals [4] = '{32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0, 32'hFEDC_BA98};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_sync_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    assign bus.req     = req_p[g];
    assign bus.we      = we_p[g];
    assign bus.addr    = addr_p[g];
    assign bus.wdata   = wdata_p[g];
    assign bus.be      = be_p[g];
    assign ready_p[g]  = bus.ready;
    assign done_p[g]   = bus.done;
    assign err_p[g]    = bus.err;
    assign rdata_p[g]  = bus.rdata;
    dmem_sync #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk   (clk),
      .reset (rst_p[g]),
      .bus   (bus)
    );
  end

  // err must never be seen without done
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      total++;
      if (err_p[k] === 1'b1 && done_p[k] !== 1'b1) begin
        bad++;
        $display("FAIL err_without_done inst=%0d err=%b done=%b", k, err_p[k], done_p[k]);
      end
    end
  end

  // Issues one access, scrambles the inputs after acceptance, then follows it
  // until ready returns; records latency, response and ready-low cycles.
  task automatic run_access(input int k, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b,
                            output int lat, output logic [31:0] rd, output logic e,
                            output int rdy_low, output int ndone);
    lat = -1; rd = 'x; e = 1'bx; rdy_low = 0; ndone = 0;
    req_p[k] = 1'b1; we_p[k] = w; addr_p[k] = a; wdata_p[k] = d; be_p[k] = b;
    @(posedge clk); #1;
    req_p[k] = 1'b0; we_p[k] = ~w; addr_p[k] = a ^ 32'h4; wdata_p[k] = ~d; be_p[k] = ~b;
    for (int n = 1; n <= 20; n++) begin
      if (done_p[k] === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = n; rd = rdata_p[k]; e = err_p[k]; end
      end
      if (ready_p[k] === 1'b1) break;
      rdy_low++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int lat, rl, nd; logic [31:0] rd; logic e;
    run_access(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, lat, rd, e, rl, nd);
    run_access(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, e, rl, nd);
    total++; if (rd !== 32'hA5A5_A5A5) begin bad++; $display("FAIL l1_read got=%h exp=%h", rd, 32'hA5A5_A5A5); end
    total++; if (lat !== 1) begin bad++; $display("FAIL l1_latency got=%0d exp=1", lat); end
    rst_p[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready_p[0] !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_p[0]); end
    total++; if (done_p[0] !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_p[0]); end
    total++; if (err_p[0] !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_p[0]); end
    total++; if (rdata_p[0] !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_p[0]); end
    rst_p[0] = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, rl, nd; logic [31:0] rd; logic e;
    run_access(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd, e, rl, nd);
    total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err got=%b exp=0", e); end
    total++; if (rl !== 3) begin bad++; $display("FAIL wr_ready_low got=%0d exp=3", rl); end
    total++; if (nd !== 1) begin bad++; $display("FAIL wr_done_count got=%0d exp=1", nd); end
    run_access(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e, rl, nd);
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=%h", rd, 32'hDEAD_BEEF); end
    total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    total++; if (rl !== 3) begin bad++; $display("FAIL rd_ready_low got=%0d exp=3", rl); end
  endtask

  task automatic test_byte_enable();
    int lat, rl, nd; logic [31:0] rd; logic e;
    run_access(1, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, lat, rd, e, rl, nd);
    run_access(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e, rl, nd);
    total++; if (rd !== 32'hDE22_BE44) begin bad++; $display("FAIL be_merge got=%h exp=%h", rd, 32'hDE22_BE44); end
    run_access(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, lat, rd, e, rl, nd);
    total++; if (lat !== 3 || e !== 1'b0) begin bad++; $display("FAIL be_zero_resp got=lat%0d/err%b exp=lat3/err0", lat, e); end
    run_access(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e, rl, nd);
    total++; if (rd !== 32'hDE22_BE44) begin bad++; $display("FAIL be_zero_keep got=%h exp=%h", rd, 32'hDE22_BE44); end
  endtask

  task automatic test_errors();
    int lat, rl, nd; logic [31:0] rd; logic e;
    run_access(1, 1'b1, 32'h0, 32'h0102_0304, 4'hF, lat, rd, e, rl, nd);
    run_access(1, 1'b0, 32'h13, 32'h0, 4'h0, lat, rd, e, rl, nd);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b exp=1", e); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL misalign_rdata got=%h exp=0", rd); end
    total++; if (lat !== 3) begin bad++; $display("FAIL misalign_latency got=%0d exp=3", lat); end
    run_access(1, 1'b1, 32'h400, 32'hBAD0_BAD0, 4'hF, lat, rd, e, rl, nd);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_err got=%b exp=1", e); end
    run_access(1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, e, rl, nd);
    total++; if (rd !== 32'h0102_0304 || e !== 1'b0) begin bad++; $display("FAIL oor_no_alias got=%h/err%b exp=%h/err0", rd, e, 32'h0102_0304); end
    run_access(1, 1'b1, 32'h12, 32'h0, 4'hF, lat, rd, e, rl, nd);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL misalign_wr_err got=%b exp=1", e); end
    run_access(1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e, rl, nd);
    total++; if (rd !== 32'hDE22_BE44) begin bad++; $display("FAIL misalign_wr_keep got=%h exp=%h", rd, 32'hDE22_BE44); end
    run_access(1, 1'b1, 32'h3FC, 32'h55AA_55AA, 4'hF, lat, rd, e, rl, nd);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL last_word_wr_err got=%b exp=0", e); end
    run_access(1, 1'b0, 32'h3FC, 32'h0, 4'h0, lat, rd, e, rl, nd);
    total++; if (rd !== 32'h55AA_55AA || e !== 1'b0) begin bad++; $display("FAIL last_word_rd got=%h/err%b exp=%h/err0", rd, e, 32'h55AA_55AA); end
  endtask

  // Starts a write of 0xCAFEF00D to 0x20 and raises reset for the edge
  // `rst_edge` cycles after acceptance.
  task automatic test_reset_mid_write(input int rst_edge, input string tag);
    int lat, rl, nd; logic [31:0] rd; logic e;
    req_p[2] = 1'b1; we_p[2] = 1'b1; addr_p[2] = 32'h20; wdata_p[2] = 32'hCAFE_F00D; be_p[2] = 4'hF;
    @(posedge clk); #1;
    req_p[2] = 1'b0;
    repeat (rst_edge - 1) begin @(posedge clk); #1; end
    rst_p[2] = 1'b1;
    nd = 0;
    @(posedge clk); #1;
    rst_p[2] = 1'b0;
    total++; if (ready_p[2] !== 1'b1 || done_p[2] !== 1'b0) begin bad++; $display("FAIL %s_after_reset got=rdy%b/done%b exp=rdy1/done0", tag, ready_p[2], done_p[2]); end
    for (int n = 0; n < 6; n++) begin
      if (done_p[2] === 1'b1) nd++;
      @(posedge clk); #1;
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL %s_no_done got=%0d exp=0", tag, nd); end
    run_access(2, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, e, rl, nd);
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL %s_dropped got=%h exp=%h", tag, rd, 32'h1234_5678); end
  endtask

  task automatic test_latency4();
    int lat, rl, nd; logic [31:0] rd; logic e;
    run_access(2, 1'b1, 32'h20, 32'h1234_5678, 4'hF, lat, rd, e, rl, nd);
    total++; if (lat !== 4 || rl !== 4) begin bad++; $display("FAIL l4_timing got=lat%0d/rl%0d exp=lat4/rl4", lat, rl); end
    test_reset_mid_write(2, "rst_busy");
    test_reset_mid_write(3, "rst_commit");
  endtask

  task automatic test_back_to_back();
    int lat, rl, nd; logic [31:0] rd; logic e;
    int idx; logic acc; logic [9:0] hist;
    idx = 0; hist = '0;
    req_p[0] = 1'b1; we_p[0] = 1'b1; be_p[0] = 4'hF;
    addr_p[0] = 32'h0; wdata_p[0] = b2b_vals[0];
    for (int c = 0; c < 10; c++) begin
      acc = ready_p[0] & req_p[0];
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin addr_p[0] = 32'(4 * idx); wdata_p[0] = b2b_vals[idx]; end
        else req_p[0] = 1'b0;
      end
      hist[c] = done_p[0];
    end
    total++; if (hist !== 10'b00_0101_0101) begin bad++; $display("FAIL b2b_done_pattern got=%b exp=%b", hist, 10'b00_0101_0101); end
    for (int i = 0; i < 4; i++) begin
      run_access(0, 1'b0, 32'(4 * i), 32'h0, 4'h0, lat, rd, e, rl, nd);
      total++; if (rd !== b2b_vals[i]) begin bad++; $display("FAIL b2b_read%0d got=%h exp=%h", i, rd, b2b_vals[i]); end
    end
  endtask

  initial begin
    rst_p = 3'b111; req_p = '0; we_p = '0; addr_p = '0; wdata_p = '0; be_p = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_p = 3'b000;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_errors();
    test_latency4();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
